// File: rtl/cfr_pkg.sv
// Shared types and helpers for the peak-CFR detection stage.
//   IQ_WIDTH / MAG_WIDTH : sample and magnitude widths
//   iq_t                 : signed I/Q sample
//   mag_t                : unsigned magnitude / threshold
//   abs_iq()             : absolute value of a sample as an unsigned IQ_WIDTH
//                          value; the most negative input maps to 2**(IQ_WIDTH-1)
package cfr_pkg;

    localparam int IQ_WIDTH  = 16;
    localparam int MAG_WIDTH = 17;

    typedef logic signed [IQ_WIDTH-1:0] iq_t;
    typedef logic [MAG_WIDTH-1:0]       mag_t;
    typedef logic [IQ_WIDTH-1:0]        abs_t;

    // Two's-complement negate in IQ_WIDTH bits. For the most negative value the
    // bit pattern is unchanged, which read as unsigned is exactly its magnitude.
    function automatic abs_t abs_iq(input iq_t x);
        abs_t r;
        if (x[IQ_WIDTH-1])
            r = abs_t'(~x) + abs_t'(1);
        else
            r = abs_t'(x);
        return r;
    endfunction

endpackage

// File: rtl/cfr_mag_approx.sv
// Two-stage magnitude approximation: mag = max(|I|,|Q|) + min(|I|,|Q|)/2.
//   clk, rst_n      : clock, asynchronous active-low reset
//   valid           : input sample valid
//   data_i, data_q  : signed input sample
//   mag_valid       : valid delayed by 2
//   mag             : magnitude, 2 cycles after the input; 0 for invalid samples
module cfr_mag_approx
    import cfr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [IQ_WIDTH-1:0]  data_i,
    input  logic [IQ_WIDTH-1:0]  data_q,
    output logic                 mag_valid,
    output logic [MAG_WIDTH-1:0] mag
);

    abs_t abs_i;
    abs_t abs_q;
    logic abs_valid;
    abs_t hi;
    abs_t lo;
    mag_t mag_next;

    // Stage 1: absolute values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_i     <= '0;
            abs_q     <= '0;
            abs_valid <= 1'b0;
        end else begin
            abs_i     <= abs_iq(iq_t'(data_i));
            abs_q     <= abs_iq(iq_t'(data_q));
            abs_valid <= valid;
        end
    end

    // Stage 2: max + min/2. Invalid samples are forced to zero magnitude so
    // they can never win the peak comparison downstream.
    always_comb begin
        hi       = (abs_i >= abs_q) ? abs_i : abs_q;
        lo       = (abs_i >= abs_q) ? abs_q : abs_i;
        mag_next = '0;
        if (abs_valid)
            mag_next = mag_t'(hi) + mag_t'(lo >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            mag_valid <= 1'b0;
        end else begin
            mag       <= mag_next;
            mag_valid <= abs_valid;
        end
    end

endmodule

// File: rtl/cfr_peak_detect.sv
// Peak-CFR detection stage. Computes an approximate magnitude per sample,
// flags local maxima above the detect threshold with minimum peak spacing,
// and forwards the I/Q stream with a fixed 4-cycle latency.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   ctrl_pc_cfr_enable               : detection enable (quasi-static)
//   ctrl_pc_cfr_detect_threshold     : peak must strictly exceed this
//   ctrl_pc_cfr_clipping_threshold   : reference for the excess amplitude
//   s_valid, s_data_i, s_data_q      : input stream, no backpressure
//   m_valid, m_data_i, m_data_q      : input stream delayed 4 cycles
//   m_peak, m_peak_mag, m_peak_excess: peak flag and its magnitude / excess
//   stat_clear, stat_peak_count      : saturating count of reported peaks
// Stream handshake: a sample transfers on every cycle with valid=1; there is
// no ready, the pipeline advances unconditionally every clock.
module cfr_peak_detect
    import cfr_pkg::*;
#(
    parameter int MIN_SPACING = 8,
    parameter int CNT_WIDTH   = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctrl_pc_cfr_enable,
    input  logic [MAG_WIDTH-1:0] ctrl_pc_cfr_detect_threshold,
    input  logic [MAG_WIDTH-1:0] ctrl_pc_cfr_clipping_threshold,
    input  logic                 s_valid,
    input  logic [IQ_WIDTH-1:0]  s_data_i,
    input  logic [IQ_WIDTH-1:0]  s_data_q,
    output logic                 m_valid,
    output logic [IQ_WIDTH-1:0]  m_data_i,
    output logic [IQ_WIDTH-1:0]  m_data_q,
    output logic                 m_peak,
    output logic [MAG_WIDTH-1:0] m_peak_mag,
    output logic [MAG_WIDTH-1:0] m_peak_excess,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] stat_peak_count
);

    localparam int BLANK_LOAD = (MIN_SPACING > 1) ? MIN_SPACING - 1 : 0;
    localparam int BLANK_W    = (MIN_SPACING > 2) ? $clog2(MIN_SPACING) : 1;

    // Data/valid delay line for the first three cycles; the output registers
    // form the fourth.
    logic [2:0]          v_pipe;
    logic [IQ_WIDTH-1:0] i_pipe [3];
    logic [IQ_WIDTH-1:0] q_pipe [3];

    // Magnitude window: m0 newest, m1 center, m2 oldest.
    mag_t m0;
    logic m0_valid;
    mag_t m1;
    logic m1_valid;
    mag_t m2;

    logic [BLANK_W-1:0]   blank;
    logic                 peak_next;
    logic [MAG_WIDTH:0]   diff;
    mag_t                 excess_next;

    cfr_mag_approx u_mag (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (s_valid),
        .data_i    (s_data_i),
        .data_q    (s_data_q),
        .mag_valid (m0_valid),
        .mag       (m0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0;
            for (int k = 0; k < 3; k++) begin
                i_pipe[k] <= '0;
                q_pipe[k] <= '0;
            end
        end else begin
            v_pipe    <= {v_pipe[1:0], s_valid};
            i_pipe[0] <= s_data_i;
            q_pipe[0] <= s_data_q;
            for (int k = 1; k < 3; k++) begin
                i_pipe[k] <= i_pipe[k-1];
                q_pipe[k] <= q_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1       <= '0;
            m1_valid <= 1'b0;
            m2       <= '0;
        end else begin
            m1       <= m0;
            m1_valid <= m0_valid;
            m2       <= m1;
        end
    end

    // Peak decision on the center tap. Strict '>' against the older neighbour
    // and '>=' against the newer one makes the first sample of a plateau win.
    always_comb begin
        peak_next = ctrl_pc_cfr_enable
                 && m1_valid
                 && (m1 > ctrl_pc_cfr_detect_threshold)
                 && (m1 > m2)
                 && (m1 >= m0)
                 && (blank == '0);
        diff        = {1'b0, m1} - {1'b0, ctrl_pc_cfr_clipping_threshold};
        excess_next = diff[MAG_WIDTH] ? '0 : diff[MAG_WIDTH-1:0];
    end

    // Blank counter: loads on a peak, then counts down every cycle whether or
    // not samples are valid. Disabling detection releases it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blank <= '0;
        else if (!ctrl_pc_cfr_enable)
            blank <= '0;
        else if (peak_next)
            blank <= BLANK_W'(BLANK_LOAD);
        else if (blank != '0)
            blank <= blank - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid       <= 1'b0;
            m_data_i      <= '0;
            m_data_q      <= '0;
            m_peak        <= 1'b0;
            m_peak_mag    <= '0;
            m_peak_excess <= '0;
        end else begin
            m_valid       <= v_pipe[2];
            m_data_i      <= i_pipe[2];
            m_data_q      <= q_pipe[2];
            m_peak        <= peak_next;
            m_peak_mag    <= peak_next ? m1 : '0;
            m_peak_excess <= peak_next ? excess_next : '0;
        end
    end

    // Counts the peak currently on m_peak; a clear in that same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_peak_count <= '0;
        else if (stat_clear)
            stat_peak_count <= '0;
        else if (m_peak && (stat_peak_count != {CNT_WIDTH{1'b1}}))
            stat_peak_count <= stat_peak_count + 1'b1;
    end

endmodule

// File: tb/tb_cfr_peak_detect.sv
module tb_cfr_peak_detect;

    localparam int CNT_W    = 4;
    localparam int STAT_MAX = 15;
    localparam int EXP_W    = 16 + 16 + 1 + 17 + 17;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [16:0] det_thr;
    logic [16:0] clip_thr;
    logic        s_valid;
    logic [15:0] s_data_i;
    logic [15:0] s_data_q;
    logic        m_valid;
    logic [15:0] m_data_i;
    logic [15:0] m_data_q;
    logic        m_peak;
    logic [16:0] m_peak_mag;
    logic [16:0] m_peak_excess;
    logic        stat_clear;
    logic [CNT_W-1:0] stat_peak_count;

    logic [EXP_W-1:0] exp_q[$];
    int total;
    int bad;
    int exp_stat;

    cfr_peak_detect #(.MIN_SPACING(8), .CNT_WIDTH(CNT_W)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .ctrl_pc_cfr_enable             (enable),
        .ctrl_pc_cfr_detect_threshold   (det_thr),
        .ctrl_pc_cfr_clipping_threshold (clip_thr),
        .s_valid                        (s_valid),
        .s_data_i                       (s_data_i),
        .s_data_q                       (s_data_q),
        .m_valid                        (m_valid),
        .m_data_i                       (m_data_i),
        .m_data_q                       (m_data_q),
        .m_peak                         (m_peak),
        .m_peak_mag                     (m_peak_mag),
        .m_peak_excess                  (m_peak_excess),
        .stat_clear                     (stat_clear),
        .stat_peak_count                (stat_peak_count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic send(input int iv, input int qv, input bit ep, input int em, input int ex);
        @(negedge clk);
        s_valid  = 1'b1;
        s_data_i = 16'(iv);
        s_data_q = 16'(qv);
        exp_q.push_back({s_data_i, s_data_q, ep, 17'(em), 17'(ex)});
        if (ep)
            exp_stat = (exp_stat >= STAT_MAX) ? STAT_MAX : exp_stat + 1;
    endtask

    task automatic send_np(input int iv, input int qv);
        send(iv, qv, 1'b0, 0, 0);
    endtask

    task automatic send_invalid(input int iv);
        @(negedge clk);
        s_valid  = 1'b0;
        s_data_i = 16'(iv);
        s_data_q = 16'(iv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid  = 1'b0;
            s_data_i = '0;
            s_data_q = '0;
        end
    endtask

    task automatic set_ctrl(input bit en, input int det, input int clip);
        @(negedge clk);
        enable   = en;
        det_thr  = 17'(det);
        clip_thr = 17'(clip);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst_n) begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got m_valid=1 expected no pending sample");
                end else begin
                    e = exp_q.pop_front();
                    check("data_i",      32'(m_data_i),      32'(e[66:51]));
                    check("data_q",      32'(m_data_q),      32'(e[50:35]));
                    check("peak",        32'(m_peak),        32'(e[34]));
                    check("peak_mag",    32'(m_peak_mag),    32'(e[33:17]));
                    check("peak_excess", 32'(m_peak_excess), 32'(e[16:0]));
                end
            end else begin
                check("peak_without_valid", 32'(m_peak), 32'd0);
            end
        end
    end

    initial begin
        int lat;
        total = 0; bad = 0; exp_stat = 0;
        rst_n = 1'b0; enable = 1'b1; det_thr = 17'd1000; clip_thr = 17'd1500;
        s_valid = 1'b0; s_data_i = '0; s_data_q = '0; stat_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset asserted mid-stream
        send_np(100, 0); send(2000, 0, 1'b1, 2000, 500); send_np(100, 0);
        idle(8);
        check("stat_before_reset", 32'(stat_peak_count), 32'(exp_stat));
        send_np(100, 0); send_np(200, 0); send_np(300, 0);
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("rst_valid",  32'(m_valid),         32'd0);
        check("rst_data_i", 32'(m_data_i),        32'd0);
        check("rst_data_q", 32'(m_data_q),        32'd0);
        check("rst_peak",   32'(m_peak),          32'd0);
        check("rst_mag",    32'(m_peak_mag),      32'd0);
        check("rst_excess", 32'(m_peak_excess),   32'd0);
        check("rst_stat",   32'(stat_peak_count), 32'd0);
        exp_q.delete();
        exp_stat = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // first post-reset sample latency
        send_np(7, -3);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) s_valid = 1'b0;
            if (m_valid) begin
                lat = k;
                break;
            end
        end
        check("first_valid_latency", 32'(lat), 32'd4);
        idle(6);

        // single peak
        set_ctrl(1'b1, 1000, 1500);
        send_np(100, 0); send_np(500, 0); send(2000, 0, 1'b1, 2000, 500);
        send_np(800, 0); send_np(100, 0);
        idle(10);
        check("stat_single", 32'(stat_peak_count), 32'(exp_stat));

        // plateau: first of the equal run wins
        send_np(100, 0); send(2000, 0, 1'b1, 2000, 500); send_np(2000, 0); send_np(100, 0);
        idle(10);
        // exactly at detect threshold: no peak
        send_np(100, 0); send_np(1000, 0); send_np(100, 0);
        idle(10);
        // above detect, below clip: excess clamps to 0
        send_np(100, 0); send(1200, 0, 1'b1, 1200, 0); send_np(100, 0);
        idle(10);
        check("stat_plateau", 32'(stat_peak_count), 32'(exp_stat));

        // blanking: peaks at 10, 14, 18; 14 falls inside the blank window
        set_ctrl(1'b1, 1000, 1400);
        for (int idx = 0; idx < 24; idx++) begin
            if (idx == 10 || idx == 18)
                send(1500, 0, 1'b1, 1500, 100);
            else if (idx == 14)
                send_np(1500, 0);
            else
                send_np(100, 0);
        end
        idle(10);
        check("stat_blank", 32'(stat_peak_count), 32'(exp_stat));

        // magnitude corners
        set_ctrl(1'b1, 0, 1400);
        idle(2);
        send(-32768, -32768, 1'b1, 49152, 47752);
        idle(10);
        send(-32768, 0, 1'b1, 32768, 31368);
        idle(10);
        set_ctrl(1'b1, 1000, 1400);
        send(300, -1000, 1'b1, 1150, 0);
        idle(10);
        // invalid sample between two lower valid samples
        send_np(500, 0); send_invalid(5000); send_np(500, 0);
        idle(10);
        check("stat_corner", 32'(stat_peak_count), 32'(exp_stat));

        // enable dropped between two peaks
        set_ctrl(1'b1, 1000, 1500);
        send_np(100, 0); send(2000, 0, 1'b1, 2000, 500); send_np(100, 0);
        idle(10);
        set_ctrl(1'b0, 1000, 1500);
        send_np(100, 0); send_np(3000, 5); send_np(100, 0);
        idle(10);
        check("stat_disabled", 32'(stat_peak_count), 32'(exp_stat));
        set_ctrl(1'b1, 1000, 1500);

        // counter saturation
        for (int n = 0; n < 10; n++) begin
            send_np(100, 0); send(2000, 0, 1'b1, 2000, 500); send_np(100, 0);
            idle(8);
        end
        idle(4);
        check("stat_saturate", 32'(stat_peak_count), 32'(exp_stat));

        // stat_clear in the same cycle as m_peak
        send_np(100, 0); send(2000, 0, 1'b1, 2000, 500); send_np(100, 0);
        idle(2);
        @(negedge clk);
        stat_clear = 1'b1;
        check("peak_at_clear", 32'(m_peak), 32'd1);
        @(negedge clk);
        stat_clear = 1'b0;
        exp_stat = 0;
        idle(8);
        check("stat_clear", 32'(stat_peak_count), 32'(exp_stat));

        // drain the scoreboard, bounded
        for (int k = 0; k < 50 && exp_q.size() != 0; k++)
            @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
